// File: rtl/accel_hex_display_if.sv
// Sample handshake between the accelerometer axis source and accel_hex_display.
//   sample_valid : one-cycle refresh pulse, sample is valid in that cycle
//   sample       : signed two's-complement axis reading, DATA_W bits
//   busy         : conversion in progress
//   done         : one-cycle pulse coincident with the HEX update
// master = sample producer, slave = display block.
interface accel_hex_display_if #(
  parameter int unsigned DATA_W = 16
);
  logic              sample_valid;
  logic [DATA_W-1:0] sample;
  logic              busy;
  logic              done;

  modport master (
    output sample_valid,
    output sample,
    input  busy,
    input  done
  );

  modport slave (
    input  sample_valid,
    input  sample,
    output busy,
    output done
  );
endinterface

// File: rtl/accel_hex_display.sv
// Signed axis sample to six DE10-Lite seven-segment displays.
// On each refresh pulse the sample is captured as sign + magnitude, the magnitude
// is converted to DIGITS BCD digits by a sequential shift-add-3 engine (DATA_W cycles),
// and the segment patterns are then registered into HEX0..HEX5 in one step.
// HEX5 carries the minus sign, HEX4..HEX0 the decimal digits.
// Ports:
//   clk       : system clock
//   rst_n     : synchronous active-low reset
//   bus       : slave side of accel_hex_display_if (sample_valid, sample, busy, done)
//   HEX0..5   : active-low segments, bit0=a .. bit6=g, bit7=DP (always off)
// Optional build macro LEADING_ZERO_BLANK_EN: blanks leading-zero digits on HEX4..HEX1
// and makes those digits blank at reset; without it all digits show, reset shows 00000.
module accel_hex_display #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  accel_hex_display_if.slave  bus,
  output logic [7:0]          HEX0,
  output logic [7:0]          HEX1,
  output logic [7:0]          HEX2,
  output logic [7:0]          HEX3,
  output logic [7:0]          HEX4,
  output logic [7:0]          HEX5
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned CntW = $clog2(DATA_W + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(DATA_W - 1);

  localparam logic [7:0] SegBlank = 8'hFF;
  localparam logic [7:0] SegMinus = 8'hBF;
  localparam logic [7:0] SegZero  = 8'hC0;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [7:0] RstDigit = SegBlank;
`else
  localparam logic [7:0] RstDigit = SegZero;
`endif

  typedef enum logic [1:0] {StIdle, StConv, StUpdate} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] mag_q, mag_d;
  logic [BcdW-1:0]   bcd_q, bcd_d;
  logic              sign_q, sign_d;
  logic              pend_q, pend_d;
  logic              pend_sign_q, pend_sign_d;
  logic [DATA_W-1:0] pend_mag_q, pend_mag_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [5:0][7:0]   hex_q, hex_d;

  logic [BcdW-1:0]   bcd_adj;
  logic [5:0][7:0]   hex_enc;
  logic              in_sign;
  logic [DATA_W-1:0] in_mag;

  // Unsigned magnitude; the most-negative input wraps to exactly 2^(DATA_W-1).
  function automatic logic [DATA_W-1:0] abs_of(input logic [DATA_W-1:0] v);
    return v[DATA_W-1] ? (~v) + DATA_W'(1) : v;
  endfunction

  function automatic logic [7:0] seg_of(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = SegBlank;
    endcase
    return s;
  endfunction

  assign in_sign = bus.sample[DATA_W-1];
  assign in_mag  = abs_of(bus.sample);

  // Add-3 correction ahead of each shift keeps every nibble a valid BCD digit.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Segment image of the finished conversion.
  always_comb begin
    logic lead;
    hex_enc = '1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      hex_enc[i] = seg_of(bcd_q[4*i +: 4]);
    end
`ifdef LEADING_ZERO_BLANK_EN
    lead = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      if (bcd_q[4*i +: 4] != 4'd0) lead = 1'b0;
      if (lead) hex_enc[i] = SegBlank;
    end
`else
    lead = 1'b0;
`endif
    // A zero result never shows a minus sign.
    hex_enc[5] = (sign_q && (bcd_q != '0)) ? SegMinus : SegBlank;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mag_d       = mag_q;
    bcd_d       = bcd_q;
    sign_d      = sign_q;
    pend_d      = pend_q;
    pend_sign_d = pend_sign_q;
    pend_mag_d  = pend_mag_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    hex_d       = hex_q;

    // Arrivals while busy (CONV or UPDATE) park in the one-deep slot; latest wins.
    if (bus.sample_valid && (state_q != StIdle)) begin
      pend_d      = 1'b1;
      pend_sign_d = in_sign;
      pend_mag_d  = in_mag;
    end

    unique case (state_q)
      StIdle: begin
        busy_d = 1'b0;
        if (bus.sample_valid || pend_q) begin
          sign_d  = bus.sample_valid ? in_sign : pend_sign_q;
          mag_d   = bus.sample_valid ? in_mag  : pend_mag_q;
          bcd_d   = '0;
          cnt_d   = '0;
          pend_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = StConv;
        end
      end
      StConv: begin
        bcd_d = {bcd_adj[BcdW-2:0], mag_q[DATA_W-1]};
        mag_d = {mag_q[DATA_W-2:0], 1'b0};
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) state_d = StUpdate;
      end
      StUpdate: begin
        hex_d  = hex_enc;
        done_d = 1'b1;
        // A sample arriving in this very cycle is newer than anything pending.
        if (bus.sample_valid || pend_q) begin
          sign_d  = bus.sample_valid ? in_sign : pend_sign_q;
          mag_d   = bus.sample_valid ? in_mag  : pend_mag_q;
          bcd_d   = '0;
          cnt_d   = '0;
          pend_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = StConv;
        end else begin
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      mag_q       <= '0;
      bcd_q       <= '0;
      sign_q      <= 1'b0;
      pend_q      <= 1'b0;
      pend_sign_q <= 1'b0;
      pend_mag_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      hex_q       <= {SegBlank, RstDigit, RstDigit, RstDigit, RstDigit, SegZero};
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mag_q       <= mag_d;
      bcd_q       <= bcd_d;
      sign_q      <= sign_d;
      pend_q      <= pend_d;
      pend_sign_q <= pend_sign_d;
      pend_mag_q  <= pend_mag_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      hex_q       <= hex_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign HEX0     = hex_q[0];
  assign HEX1     = hex_q[1];
  assign HEX2     = hex_q[2];
  assign HEX3     = hex_q[3];
  assign HEX4     = hex_q[4];
  assign HEX5     = hex_q[5];

endmodule

// File: tb/tb_accel_hex_display.sv
// Self-checking bench for accel_hex_display (DATA_W=16).
// Expected displays come from a decimal model: |v| split into digits with / and %.
module tb_accel_hex_display;

  logic clk;
  logic rst_n;
  logic [7:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic [47:0] hexbus;

  accel_hex_display_if #(.DATA_W(16)) bus ();

  accel_hex_display #(
    .DATA_W (16),
    .DIGITS (5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .HEX0  (HEX0),
    .HEX1  (HEX1),
    .HEX2  (HEX2),
    .HEX3  (HEX3),
    .HEX4  (HEX4),
    .HEX5  (HEX5)
  );

  assign hexbus = {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Pulse schedule for run_seq and what it observed.
  int          pv [3];
  int          po [3];
  int          np;
  int          done_at [$];
  logic [47:0] done_hex [$];
  logic        busy_tr [$];

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [47:0] RstHex = 48'hFF_FF_FF_FF_FF_C0;
`else
  localparam logic [47:0] RstHex = 48'hFF_C0_C0_C0_C0_C0;
`endif

  function automatic logic [7:0] digit_seg(input int d);
    case (d)
      0: return 8'hC0;
      1: return 8'hF9;
      2: return 8'hA4;
      3: return 8'hB0;
      4: return 8'h99;
      5: return 8'h92;
      6: return 8'h82;
      7: return 8'hF8;
      8: return 8'h80;
      default: return 8'h90;
    endcase
  endfunction

  function automatic logic [47:0] exp_hex(input int v);
    int mag;
    int p;
    logic [47:0] r;
    mag = (v < 0) ? -v : v;
    p = 1;
    for (int i = 0; i < 5; i++) begin
      r[8*i +: 8] = digit_seg((mag / p) % 10);
`ifdef LEADING_ZERO_BLANK_EN
      if (i > 0 && mag < p) r[8*i +: 8] = 8'hFF;
`endif
      p = p * 10;
    end
    r[47:40] = (v < 0) ? 8'hBF : 8'hFF;
    return r;
  endfunction

  // Edge 0 of the sequence is the first edge after the task starts; pulses with
  // offset n are sampled at edge n. Observations are taken #1 after each edge.
  task automatic run_seq(input int ncyc);
    done_at.delete();
    done_hex.delete();
    busy_tr.delete();
    @(posedge clk); #1;
    for (int n = 0; n <= ncyc; n++) begin
      bus.sample_valid = 1'b0;
      for (int i = 0; i < np; i++) begin
        if (po[i] == n) begin
          bus.sample_valid = 1'b1;
          bus.sample = pv[i][15:0];
        end
      end
      @(posedge clk); #1;
      busy_tr.push_back(bus.busy);
      if (bus.done) begin
        done_at.push_back(n);
        done_hex.push_back(hexbus);
      end
    end
    bus.sample_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.sample_valid = 1'b0;
    bus.sample = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", bus.busy); end
    n_checks++;
    if (bus.done !== 1'b0) begin n_fail++; $display("FAIL rst_done got %b want 0", bus.done); end
    n_checks++;
    if (hexbus !== RstHex) begin
      n_fail++; $display("FAIL rst_hex got %h want %h", hexbus, RstHex);
    end
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy got %b want 0", bus.busy); end
    n_checks++;
    if (bus.done !== 1'b0) begin n_fail++; $display("FAIL idle_done got %b want 0", bus.done); end
    n_checks++;
    if (hexbus !== RstHex) begin
      n_fail++; $display("FAIL idle_hex got %h want %h", hexbus, RstHex);
    end
  endtask

  task automatic test_directed();
    int vals [3];
    vals[0] = 123;
    vals[1] = -256;
    vals[2] = -32768;
    for (int k = 0; k < 3; k++) begin
      np = 1; pv[0] = vals[k]; po[0] = 0;
      run_seq(25);
      n_checks++;
      if (done_at.size() !== 1) begin
        n_fail++; $display("FAIL dir_count v=%0d got %0d want 1", vals[k], done_at.size());
      end
      if (done_at.size() >= 1) begin
        n_checks++;
        if (done_at[0] !== 17) begin
          n_fail++; $display("FAIL dir_latency v=%0d got %0d want 17", vals[k], done_at[0]);
        end
        n_checks++;
        if (done_hex[0] !== exp_hex(vals[k])) begin
          n_fail++;
          $display("FAIL dir_hex v=%0d got %h want %h", vals[k], done_hex[0], exp_hex(vals[k]));
        end
      end
      n_checks++;
      if (busy_tr[0] !== 1'b1 || busy_tr[16] !== 1'b1 || busy_tr[17] !== 1'b0) begin
        n_fail++;
        $display("FAIL dir_busy v=%0d got %b%b%b want 110", vals[k],
                 busy_tr[0], busy_tr[16], busy_tr[17]);
      end
    end
  endtask

  task automatic test_back_to_back();
    np = 3;
    pv[0] = 5; po[0] = 0;
    pv[1] = 7; po[1] = 3;
    pv[2] = 9; po[2] = 6;
    run_seq(55);
    n_checks++;
    if (done_at.size() !== 2) begin
      n_fail++; $display("FAIL b2b_count got %0d want 2", done_at.size());
    end
    if (done_at.size() >= 2) begin
      n_checks++;
      if (done_at[0] !== 17 || done_at[1] !== 34) begin
        n_fail++; $display("FAIL b2b_timing got %0d,%0d want 17,34", done_at[0], done_at[1]);
      end
      n_checks++;
      if (done_hex[0] !== exp_hex(5)) begin
        n_fail++; $display("FAIL b2b_first got %h want %h", done_hex[0], exp_hex(5));
      end
      n_checks++;
      if (done_hex[1] !== exp_hex(9)) begin
        n_fail++; $display("FAIL b2b_second got %h want %h", done_hex[1], exp_hex(9));
      end
    end
  endtask

  task automatic test_random();
    int v1, v2, v3, j2, j3, mode, last;
    for (int it = 0; it < 24; it++) begin
      v1 = int'($urandom_range(65535)) - 32768;
      v2 = int'($urandom_range(65535)) - 32768;
      v3 = int'($urandom_range(65535)) - 32768;
      mode = int'($urandom_range(2));
      np = 1; pv[0] = v1; po[0] = 0;
      last = v1;
      if (mode >= 1) begin
        // Offset 17 lands exactly in the UPDATE cycle.
        j2 = (it % 4 == 0) ? 17 : int'($urandom_range(1, 17));
        np = 2; pv[1] = v2; po[1] = j2;
        last = v2;
        if (mode == 2) begin
          j3 = int'($urandom_range(1, 17));
          np = 3; pv[2] = v3; po[2] = j3;
          last = (j3 >= j2) ? v3 : v2;
        end
      end
      run_seq(45);
      n_checks++;
      if (done_at.size() !== ((np == 1) ? 1 : 2)) begin
        n_fail++; $display("FAIL rnd_count it=%0d got %0d want %0d", it, done_at.size(),
                           (np == 1) ? 1 : 2);
      end
      if (done_at.size() >= 1) begin
        n_checks++;
        if (done_at[0] !== 17 || done_hex[0] !== exp_hex(v1)) begin
          n_fail++; $display("FAIL rnd_first it=%0d v=%0d got t=%0d %h want t=17 %h", it, v1,
                             done_at[0], done_hex[0], exp_hex(v1));
        end
      end
      if (np > 1 && done_at.size() >= 2) begin
        n_checks++;
        if (done_at[1] !== 34 || done_hex[1] !== exp_hex(last)) begin
          n_fail++; $display("FAIL rnd_second it=%0d v=%0d got t=%0d %h want t=34 %h", it,
                             last, done_at[1], done_hex[1], exp_hex(last));
        end
      end
    end
  endtask

  task automatic test_reset_mid_conv();
    int seen;
    seen = 0;
    @(posedge clk); #1;
    bus.sample_valid = 1'b1;
    bus.sample = 16'hFFFF;
    @(posedge clk); #1;
    bus.sample_valid = 1'b0;
    for (int n = 1; n <= 7; n++) begin
      @(posedge clk); #1;
      if (bus.done) seen++;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy got %b want 0", bus.busy); end
    n_checks++;
    if (hexbus !== RstHex) begin
      n_fail++; $display("FAIL mid_hex got %h want %h", hexbus, RstHex);
    end
    if (bus.done) seen++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk); #1;
      if (bus.done) seen++;
    end
    n_checks++;
    if (seen !== 0) begin n_fail++; $display("FAIL mid_no_done got %0d want 0", seen); end
    np = 1; pv[0] = 0; po[0] = 0;
    run_seq(25);
    n_checks++;
    if (done_at.size() !== 1) begin
      n_fail++; $display("FAIL mid_zero_count got %0d want 1", done_at.size());
    end
    if (done_at.size() >= 1) begin
      n_checks++;
      if (done_hex[0] !== exp_hex(0)) begin
        n_fail++; $display("FAIL mid_zero_hex got %h want %h", done_hex[0], exp_hex(0));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.sample_valid = 1'b0;
    bus.sample = '0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_mid_conv();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/accel_hex_display.md
Name: accel_hex_display

Overview:
- Downstream consumer of the accelerometer axis sample in the top-level accelerometer design.
- On each refresh pulse it captures one signed axis reading and converts its magnitude to decimal with a sequential shift-add-3 (double-dabble) engine.
- Drives six DE10-Lite seven-segment displays: HEX5 carries the sign, HEX4..HEX0 carry the decimal digits.
- Display outputs update atomically only when a conversion completes.

Parameters:
- DATA_W, 16, width of the signed two's-complement input sample. Legal range 2..16.
- DIGITS, 5, number of BCD digits produced. Fixed at 5; covers magnitudes up to 32768.

Ports:
- clk  input  1  system clock (50 MHz MAX10_CLK1_50 domain).
- rst_n  input  1  synchronous active-low reset.
- sample_valid  input  1  one-cycle refresh pulse; sample is valid in that cycle.
- sample  input  DATA_W  signed axis reading (sign-extended ADXL345 data).
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse, coincident with the HEX update.
- HEX0..HEX5  output  8 each  active-low segments: bit0=a .. bit6=g, bit7=DP. DP is always 1 (off).

Behaviour:
- Reset (rst_n low at a clk edge):
  - State goes to IDLE; busy=0, done=0; pending flag cleared.
  - HEX5..HEX1 = 8'hFF (blank), HEX0 = 8'hC0 ("0").
  - Reset wins over any other event in the same cycle, including mid-conversion. A partial result is discarded and the HEX outputs revert to their reset values.
- Capture and sign handling:
  - When sample_valid=1 in IDLE, the block registers sign = sample[DATA_W-1] and mag = |sample|, computed as a DATA_W-bit unsigned value.
  - The most-negative input (-2^(DATA_W-1)) therefore yields the correct magnitude 2^(DATA_W-1).
- State machine IDLE -> CONV -> UPDATE -> IDLE:
  - IDLE: busy=0. Leaves IDLE on sample_valid or when the pending flag is set.
  - CONV: busy=1. Runs exactly DATA_W cycles. Each cycle, every BCD nibble >= 5 gets +3, then {bcd, mag} shifts left by 1. The BCD register is 4*DIGITS bits wide, cleared at capture.
  - UPDATE: busy=1, one cycle. The segment encoding is registered into HEX0..HEX5 and done pulses on the cycle those values first appear.
- Latency: sample_valid at edge k -> new HEX values and done=1 visible after edge k+DATA_W+1 (17 cycles for DATA_W=16).
- Back-to-back samples: sample_valid while busy=1 is not dropped.
  - It loads a one-deep pending register (sign, mag) and sets the pending flag; a later arrival overwrites it (latest wins).
  - From UPDATE, if pending is set, the FSM goes directly to CONV using the pending data and clears the flag. Otherwise it returns to IDLE.
  - sample_valid arriving in the UPDATE cycle itself is also treated as pending.
- Digit encoding: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
- Sign: HEX5 = 8'hBF (minus, segment g only) when sign=1 and mag != 0; otherwise 8'hFF.
- done is high only in the UPDATE-output cycle. busy is high from the cycle after capture through the UPDATE cycle.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - Leading-zero digits in HEX4..HEX1 are driven 8'hFF; HEX0 always shows its digit.
  - The minus sign stays on HEX5 regardless of blanking.
  - Reset values are as listed under Behaviour.
- Undefined:
  - All five digits are always shown, including leading zeros.
  - Reset values become HEX4..HEX0 = 8'hC0 and HEX5 = 8'hFF.

Test Plan:
- Reset, then idle 20 cycles -> busy=0, done=0, HEX0=C0, HEX5..HEX1=FF (blank-enabled build).
- sample=+123 pulse -> done exactly 17 cycles later; HEX0=B0, HEX1=A4, HEX2=F9, HEX3=FF, HEX4=FF, HEX5=FF. Without the macro, HEX3=HEX4=C0.
- sample=-256 -> HEX5=BF, HEX2=A4, HEX1=92, HEX0=82, HEX4=HEX3=FF.
- sample=-32768 (16'h8000) -> HEX5=BF, HEX4=B0, HEX3=A4, HEX2=F8, HEX1=82, HEX0=80.
- Pulse +5, then +7 and +9 while busy -> first done shows 5. A second done follows 17 cycles later showing 9; 7 is never displayed.
- Start -1 conversion, assert rst_n=0 at CONV cycle 8 -> next cycle busy=0, HEX at reset values, no done pulse; a subsequent +0 shows HEX0=C0, HEX5=FF.
